// File: rtl/add32_seq_pkg.sv
// Shared types and sizes for the byte-serial 32-bit add/subtract unit.
package add32_seq_pkg;
    localparam int BYTE_W = 8;
    localparam int NBYTES = 4;
    localparam int IDX_W  = 2;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } add_state_t;
endpackage

// File: rtl/add32_seq_ctrl_add8_slice.sv
// Combinational 8-bit ripple-carry slice built from 1-bit full adders.
module add8_slice
    import add32_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              ci,
    output logic [BYTE_W-1:0] s,
    output logic              co
);
    logic [BYTE_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < BYTE_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[BYTE_W];
endmodule

// File: rtl/add32_seq_ctrl.sv
// Sequential 32-bit add/subtract: one 8-bit slice reused over four cycles, LSB first,
// with valid/ready handshakes on operands and result.
//   state | meaning
//   IDLE  | in_ready=1, waiting for operands
//   BUSY  | adding byte idx_q, carry held in carry_q
//   DONE  | out_valid=1, result held until out_ready
module add32_seq_ctrl
    import add32_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] sum,
    output logic        cout,
    output logic        ovf
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    add_state_t        state_q, state_d;
    logic [31:0]       a_q, b_q, sum_q;
    logic              carry_q, cout_q, ovf_q;
    logic [IDX_W-1:0]  idx_q;
    logic [4:0]        bit_lo;
    logic [BYTE_W-1:0] slice_s;
    logic              slice_co;
    logic              accept, step, last;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_ready && in_valid;
    assign step      = (state_q == BUSY);
    assign last      = (idx_q == LAST_IDX);
    assign bit_lo    = {idx_q, 3'b000};

    add8_slice u_slice (
        .a  (a_q[bit_lo +: BYTE_W]),
        .b  (b_q[bit_lo +: BYTE_W]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = BUSY;
            BUSY:    if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1, so b is inverted at capture and the carry seeded with 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            idx_q   <= '0;
        end else if (step) begin
            sum_q[bit_lo +: BYTE_W] <= slice_s;
            carry_q <= slice_co;
            idx_q   <= idx_q + IDX_W'(1);
            if (last) begin
                cout_q <= slice_co;
                ovf_q  <= (a_q[31] == b_q[31]) && (slice_s[BYTE_W-1] != a_q[31]);
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_add32_seq_ctrl.sv
// Directed self-checking bench for add32_seq_ctrl: vector table plus reset,
// back-pressure and back-to-back sequences.
module tb_add32_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, sum;
    logic        cin, sub, cout, ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    add32_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Counts edges until out_valid is seen; gives up after 20.
    task automatic wait_result(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) chk("result_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int n;
        @(negedge clk);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub;
        in_valid = 1'b1; out_ready = 1'b0;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = ~cin; sub = ~sub;
        wait_result(n);
        chk({tag, "_latency"}, 32'(n), 32'd4);
        chk({tag, "_sum"},  sum, v.sum);
        chk({tag, "_cout"}, 32'(cout), 32'(v.cout));
        chk({tag, "_ovf"},  32'(ovf),  32'(v.ovf));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_handoff_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_handoff_ready"}, 32'(in_ready),  32'd1);
    endtask

    initial begin
        int n;
        vec_t v;
        vecs[0] = '{32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[5] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[6] = '{32'h0000_000A, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
        vecs[7] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum",       sum,            32'd0);
        chk("rst_cout",      32'(cout),      32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // Abort mid-BUSY: two bytes written, then asynchronous reset.
        @(negedge clk);
        a = 32'h0F0F_0F0F; b = 32'h0101_0101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("midbusy_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_sum",       sum,            32'd0);
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(vecs[0], "post_reset");

        // Back-pressure in DONE with in_valid high and operands changing.
        @(negedge clk);
        a = 32'h0000_0100; b = 32'h0000_0023; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        wait_result(n);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = $urandom; b = $urandom; cin = $urandom; sub = $urandom;
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready",  32'(in_ready),  32'd0);
            chk("bp_sum",       sum,            32'h0000_0123);
        end
        @(negedge clk);
        a = 32'd3; b = 32'd4; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_handoff_valid", 32'(out_valid), 32'd0);
        chk("bp_handoff_ready", 32'(in_ready),  32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_next_accept", 32'(in_ready), 32'd0);
        wait_result(n);
        chk("bp_next_latency", 32'(n), 32'd4);
        chk("bp_next_sum",     sum,    32'd7);
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Back-to-back with in_valid and out_ready tied high.
        begin
            vec_t bb[3];
            bb[0] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0};
            bb[1] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
            bb[2] = '{32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0};
            @(negedge clk);
            a = bb[0].a; b = bb[0].b; cin = bb[0].cin; sub = bb[0].sub;
            in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("b2b%0d_accepted", i), 32'(in_ready), 32'd0);
                if (i < 2) begin
                    v = bb[i+1];
                    a = v.a; b = v.b; cin = v.cin; sub = v.sub;
                end else begin
                    in_valid = 1'b0;
                end
                wait_result(n);
                chk($sformatf("b2b%0d_latency", i), 32'(n), 32'd4);
                chk($sformatf("b2b%0d_sum", i), sum, bb[i].sum);
                @(posedge clk); #1;
                chk($sformatf("b2b%0d_handoff", i), 32'(in_ready), 32'd1);
                if (i < 2) begin
                    @(posedge clk); #1;
                end
            end
            out_ready = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
